// File: rtl/rx_cmd_exec.sv
// Receiver command executor: qualifies 7-bit command words, tracks motion mode and speed,
// and drives PWM-gated H-bridge inputs. Define WDT_EN to add the command watchdog.
module rx_cmd_exec #(
   parameter int STABLE_CYCLES = 1000,
   parameter int PWM_PERIOD    = 1000,
   parameter int WDT_CYCLES    = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] rx,
   output logic [1:0] motor_l,
   output logic [1:0] motor_r,
   output logic       cmd_valid,
   output logic [3:0] cmd,
   output logic [2:0] speed,
   output logic       hdr_err
);

   localparam int CW   = $clog2(STABLE_CYCLES + 1);
   localparam int PW   = $clog2(PWM_PERIOD);
   localparam int TW   = PW + 4;
   localparam int STEP = PWM_PERIOD / 8;

   if (STABLE_CYCLES < 2 || (PWM_PERIOD % 8) != 0 || WDT_CYCLES < 2) begin : g_bad_params
      $error("rx_cmd_exec: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, QUAL, EXEC} state_t;
   typedef enum logic [2:0] {STOP, FWD, BACK, LEFT, RIGHT, SPIN} mode_t;

   state_t        state;
   mode_t         mode;
   logic [6:0]    rx_q;
   logic [6:0]    cand;
   logic [6:0]    last_word;
   logic [CW-1:0] cnt;
   logic [PW-1:0] pwm_cnt;
   logic [TW-1:0] pwm_thresh;
   logic          pwm_on;
   logic          code_ok;
   logic [1:0]    pat_l;
   logic [1:0]    pat_r;

`ifdef WDT_EN
   localparam int WW = $clog2(WDT_CYCLES);
   logic [WW-1:0] wdt_cnt;
`endif

   assign code_ok    = (rx_q[3:0] != 4'd0) && (rx_q[3:0] <= 4'd8);
   assign pwm_thresh = TW'({1'b0, speed} + 4'd1) * TW'(STEP);
   assign pwm_on     = TW'(pwm_cnt) < pwm_thresh;

   always_comb begin
      pat_l = 2'b00;
      pat_r = 2'b00;
      case (mode)
         FWD:     begin pat_l = 2'b10; pat_r = 2'b10; end
         BACK:    begin pat_l = 2'b01; pat_r = 2'b01; end
         LEFT:    begin pat_l = 2'b00; pat_r = 2'b10; end
         RIGHT:   begin pat_l = 2'b10; pat_r = 2'b00; end
         SPIN:    begin pat_l = 2'b10; pat_r = 2'b01; end
         default: begin pat_l = 2'b00; pat_r = 2'b00; end
      endcase
   end

   // Free-running PWM counter and registered, gated motor drive
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         motor_l <= 2'b00;
         motor_r <= 2'b00;
      end else begin
         if (pwm_cnt == PW'(PWM_PERIOD - 1)) pwm_cnt <= '0;
         else                                pwm_cnt <= pwm_cnt + PW'(1);
         motor_l <= pwm_on ? pat_l : 2'b00;
         motor_r <= pwm_on ? pat_r : 2'b00;
      end
   end

   // Qualification FSM; the last accepted word makes actions fire only on a code change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q      <= '0;
         state     <= IDLE;
         cand      <= '0;
         cnt       <= '0;
         last_word <= '0;
         cmd       <= '0;
         cmd_valid <= 1'b0;
         speed     <= 3'd3;
         hdr_err   <= 1'b0;
         mode      <= STOP;
`ifdef WDT_EN
         wdt_cnt   <= '0;
`endif
      end else begin
         rx_q      <= rx;
         cmd_valid <= 1'b0;
`ifdef WDT_EN
         if (cmd_valid) begin
            wdt_cnt <= '0;
         end else if (wdt_cnt != WW'(WDT_CYCLES - 1)) begin
            wdt_cnt <= wdt_cnt + WW'(1);
         end else if (mode != STOP) begin
            mode      <= STOP;
            last_word <= '0;
         end
`endif
         case (state)
            IDLE: begin
               if (rx_q != last_word && code_ok) begin
                  cand  <= rx_q;
                  cnt   <= '0;
                  state <= QUAL;
               end
            end
            QUAL: begin
               if (rx_q != cand) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(STABLE_CYCLES - 2)) state <= EXEC;
               end
            end
            EXEC: begin
               last_word <= cand;
               state     <= IDLE;
               if (cand[6:4] != 3'b100) begin
                  hdr_err <= 1'b1;
               end else begin
                  cmd       <= cand[3:0];
                  cmd_valid <= 1'b1;
                  case (cand[3:0])
                     4'd1: mode <= FWD;
                     4'd2: mode <= BACK;
                     4'd3: mode <= LEFT;
                     4'd4: mode <= RIGHT;
                     4'd5: mode <= STOP;
                     4'd6: if (speed != 3'd7) speed <= speed + 3'd1;
                     4'd7: if (speed != 3'd0) speed <= speed - 3'd1;
                     4'd8: mode <= SPIN;
                     default: ;
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_cmd_exec.sv
// Randomized bench for rx_cmd_exec: words are held as segments and a segment-level
// model predicts executions, speed, header errors and PWM duty over one full period.
module tb_rx_cmd_exec;

   localparam int S = 4;
   localparam int P = 16;
   localparam int W = 100;

   localparam int M_STOP  = 0;
   localparam int M_FWD   = 1;
   localparam int M_BACK  = 2;
   localparam int M_LEFT  = 3;
   localparam int M_RIGHT = 4;
   localparam int M_SPIN  = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] rx;
   logic [1:0] motor_l;
   logic [1:0] motor_r;
   logic       cmd_valid;
   logic [3:0] cmd;
   logic [2:0] speed;
   logic       hdr_err;

   int compared   = 0;
   int mismatched = 0;

   logic [6:0] mLast;
   logic [3:0] mCmd;
   int         mSpeed;
   int         mMode;
   logic       mHdrErr;
   logic [6:0] prevWord;

   rx_cmd_exec #(.STABLE_CYCLES(S), .PWM_PERIOD(P), .WDT_CYCLES(W)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx),
      .motor_l(motor_l), .motor_r(motor_r),
      .cmd_valid(cmd_valid), .cmd(cmd), .speed(speed), .hdr_err(hdr_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic logic [3:0] patOf(input int m);
      case (m)
         M_FWD:   return 4'b1010;
         M_BACK:  return 4'b0101;
         M_LEFT:  return 4'b0010;
         M_RIGHT: return 4'b1000;
         M_SPIN:  return 4'b1001;
         default: return 4'b0000;
      endcase
   endfunction

   // Hold one word for len rising edges; count pulses and classify motors over the last P cycles
   task automatic applyStimulus(input logic [6:0] word, input int len, input logic [3:0] pat,
                                output int pulses, output int onCnt, output int badCnt);
      logic [3:0] mot;
      rx = word;
      pulses = 0; onCnt = 0; badCnt = 0;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (cmd_valid === 1'b1) pulses++;
         if (i >= len - P) begin
            mot = {motor_l, motor_r};
            if (pat != 4'b0000 && mot === pat) onCnt++;
            else if (mot !== 4'b0000) badCnt++;
         end
      end
   endtask

   task automatic runSegment(input logic [6:0] word, input bit isLong);
      int len, pulses, onCnt, badCnt, expPulses;
      logic [3:0] code;
      code = word[3:0];
      expPulses = 0;
      if (word == prevWord) isLong = 1'b1;
      len = isLong ? (S + 4 + P + $urandom_range(0, 3)) : $urandom_range(1, S - 1);
      if (isLong && code >= 4'd1 && code <= 4'd8 && word != mLast) begin
         mLast = word;
         if (word[6:4] != 3'b100) begin
            mHdrErr = 1'b1;
         end else begin
            expPulses = 1;
            mCmd = code;
            case (code)
               4'd1: mMode = M_FWD;
               4'd2: mMode = M_BACK;
               4'd3: mMode = M_LEFT;
               4'd4: mMode = M_RIGHT;
               4'd5: mMode = M_STOP;
               4'd6: mSpeed = (mSpeed < 7) ? mSpeed + 1 : 7;
               4'd7: mSpeed = (mSpeed > 0) ? mSpeed - 1 : 0;
               4'd8: mMode = M_SPIN;
               default: ;
            endcase
         end
      end
      applyStimulus(word, len, patOf(mMode), pulses, onCnt, badCnt);
      checkOutput("pulses", pulses, expPulses);
      checkOutput("hdr_err", hdr_err, mHdrErr);
      if (isLong) begin
         checkOutput("cmd", cmd, mCmd);
         checkOutput("speed", speed, mSpeed);
         checkOutput("duty_on", onCnt, (patOf(mMode) == 4'b0000) ? 0 : (mSpeed + 1) * P / 8);
         checkOutput("motor_bad", badCnt, 0);
      end
      prevWord = word;
   endtask

   task automatic modelReset();
      mLast = 7'h00; mCmd = 4'd0; mSpeed = 3; mMode = M_STOP; mHdrErr = 1'b0; prevWord = 7'h00;
   endtask

   initial begin
      int first, pulses, onCnt, badCnt, pick;
      logic [6:0] word;
      logic [2:0] hdr;
      logic [3:0] code;

      rst_n = 1'b0;
      rx    = 7'h00;
      modelReset();
      repeat (3) @(negedge clk);
      checkOutput("rst_motors", {motor_l, motor_r}, 0);
      checkOutput("rst_cmd_valid", cmd_valid, 0);
      checkOutput("rst_cmd", cmd, 0);
      checkOutput("rst_speed", speed, 3);
      checkOutput("rst_hdr_err", hdr_err, 0);
      rst_n = 1'b1;

      // First command: exact latency, single pulse, duty 4/8 forward
      rx = 7'b1000001;
      first = 0; pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (cmd_valid === 1'b1) begin
            pulses++;
            if (first == 0) first = k;
         end
      end
      checkOutput("latency", first, S + 2);
      checkOutput("first_pulses", pulses, 1);
      checkOutput("first_cmd", cmd, 1);
      mLast = 7'b1000001; mCmd = 4'd1; mMode = M_FWD; prevWord = 7'b1000001;
      applyStimulus(7'b1000001, P, patOf(M_FWD), pulses, onCnt, badCnt);
      checkOutput("held_pulses", pulses, 0);
      checkOutput("first_duty", onCnt, 8);
      checkOutput("first_bad", badCnt, 0);

      for (int n = 0; n < 250; n++) begin
         if (($urandom % 10) < 2) begin
            word = mLast;
         end else begin
            hdr = (($urandom % 8) == 0) ? 3'($urandom) : 3'b100;
            pick = $urandom % 20;
            if (pick < 12)       code = 4'($urandom_range(1, 8));
            else if (pick < 16)  code = 4'd6;
            else if (pick < 18)  code = 4'd7;
            else if (pick == 18) code = 4'd0;
            else                 code = 4'($urandom_range(9, 15));
            word = {hdr, code};
         end
         runSegment(word, ($urandom % 3) != 0);
      end

      // Asynchronous reset in the middle of forward motion
      runSegment(7'h45, 1'b1);
      runSegment(7'h41, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_motors", {motor_l, motor_r}, 0);
      checkOutput("async_speed", speed, 3);
      checkOutput("async_cmd", cmd, 0);
      checkOutput("async_hdr_err", hdr_err, 0);
      rx = 7'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      runSegment(7'h41, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rx_cmd_exec.md
Name: rx_cmd_exec

Overview:
- Consumes the 7-bit receiver command word and turns it into motion for the smart car.
- Word format: rx[6]=1, rx[5:4]=00, rx[3:0]=key code 1..8.
- Qualifies the word (header check plus stability filter) and fires a one-cycle command strobe when an accepted code changes.
- Holds the current motion mode and speed level, and drives the two H-bridge motor input pairs through a PWM gate.
- Sits between the receiver front end (real or key-emulated) and the motor driver pins.

Parameters:
- STABLE_CYCLES, 1000: number of consecutive cycles a candidate word must hold before acceptance (≥2).
- PWM_PERIOD, 1000: PWM period in clk cycles; must be a multiple of 8.
- WDT_CYCLES, 50_000_000: watchdog timeout in cycles. Used only when WDT_EN is defined.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  7  receiver command word {hdr[2:0], code[3:0]}
- motor_l  output  2  left motor {IN1,IN2}
- motor_r  output  2  right motor {IN1,IN2}
- cmd_valid  output  1  one-cycle pulse when a command executes
- cmd  output  4  last executed code
- speed  output  3  current speed level 0..7
- hdr_err  output  1  sticky flag; set when a stable word has header ≠ 3'b100

Behaviour:
- Reset values: motor_l=00, motor_r=00, cmd_valid=0, cmd=0, speed=3, hdr_err=0, mode=STOP, FSM=IDLE, last accepted word=7'h00.

- Input register: rx is registered once (rx_q). All logic uses rx_q.

- FSM:
  - IDLE:
    - If rx_q ≠ last accepted word and rx_q[3:0] is in 1..8: latch candidate, clear counter, go to QUAL.
    - Codes 0 and 9..15 are ignored and the FSM stays in IDLE.
  - QUAL:
    - If rx_q ≠ candidate: return to IDLE. No strobe.
    - Otherwise increment counter. When counter reaches STABLE_CYCLES-1, go to EXEC.
  - EXEC (one cycle):
    - If header ≠ 100: set hdr_err, update last accepted word, no strobe.
    - Otherwise: cmd ← code, cmd_valid=1 in this cycle, apply action, update last accepted word.
    - Return to IDLE.

- Latency: an rx change to a stable valid word produces cmd_valid exactly STABLE_CYCLES+2 cycles later (1 for input register, STABLE_CYCLES for qualification, 1 for EXEC).

- Repeats: the same code held or re-presented without an intervening different accepted word executes only once. Actions are edge-triggered on accepted-code change.

- Actions by code:
  - 1: mode=FWD
  - 2: mode=BACK
  - 3: mode=LEFT
  - 4: mode=RIGHT
  - 5: mode=STOP
  - 6: speed+1, saturating at 7; mode unchanged
  - 7: speed-1, saturating at 0; mode unchanged
  - 8: mode=SPIN

- Motor pattern (before PWM gating), given as motor_l / motor_r:
  - STOP: 00 / 00
  - FWD: 10 / 10
  - BACK: 01 / 01
  - LEFT: 00 / 10
  - RIGHT: 10 / 00
  - SPIN: 10 / 01

- PWM:
  - Free-running counter 0..PWM_PERIOD-1, wraps to 0.
  - pwm_on = (counter < (speed+1)*(PWM_PERIOD/8)).
  - At speed 7, pwm_on is constantly 1.
  - Motor outputs are registered: the pattern when pwm_on=1, 00 otherwise.
  - A speed change takes effect on the next compare; the PWM counter is not reset.

- hdr_err: cleared only by reset.

- Reset asserted mid-QUAL or mid-motion: all state returns to its reset value immediately (asynchronously). Motors stop.

Optional Feature:
- Macro: WDT_EN.
- Defined:
  - A watchdog counter clears on every cmd_valid.
  - When the counter reaches WDT_CYCLES-1 and mode ≠ STOP: mode is forced to STOP (speed unchanged), no cmd_valid, counter saturates.
  - The last accepted word is cleared to 7'h00, so re-presenting the held code is accepted again.
- Undefined:
  - No watchdog logic.
  - Mode persists until the next command.

Test Plan:
- Reset, then rx=7'b1000001 held; with STABLE_CYCLES=4 → cmd_valid pulses once at cycle 6 with cmd=1. motor_l=motor_r=10 gated at duty 4/8 (speed 3). No further pulses while rx is held.
- Glitch: rx=1000011 for 2 cycles then back to the prior word (STABLE_CYCLES=4) → no cmd_valid, mode unchanged.
- Speed: code 6, code 1, code 6, … alternating ×6 → speed saturates at 7, motors are constant 10/10 in FWD. Then code 7 then code 5 → speed=6, motors 00/00.
- Bad header: rx=7'b0000010 stable → hdr_err=1, no cmd_valid, mode unchanged. Then rx=1000010 → cmd_valid, mode=BACK (01/01).
- Invalid code: rx=1001001 (code 9) or 1000000 held → FSM stays IDLE, no outputs change.
- WDT_EN with WDT_CYCLES=100: code 8 → SPIN. After 100 cycles with no command → motors 00/00, no cmd_valid. Holding code 8 then re-executes SPIN after qualification.
